// File: rtl/tx_ctl_pkg.sv
// Shared constants and control-word decode for the transmitter control interface.
package tx_ctl_pkg;
    localparam int STREAM_WIDTH    = 32;
    localparam int UNDERFLOW_WIDTH = 16;
    localparam int CTL_TX_EN_BIT   = 0;
    localparam int CTL_AM_EN_BIT   = 1;
    localparam int CTL_FLUSH_BIT   = 2;

    typedef struct packed {
        logic flush;
        logic am_en;
        logic tx_en;
    } ctl_cmd_t;

    function automatic ctl_cmd_t decode_ctl(input logic [2:0] w);
        ctl_cmd_t c;
        c.tx_en = w[CTL_TX_EN_BIT];
        c.am_en = w[CTL_AM_EN_BIT];
        c.flush = w[CTL_FLUSH_BIT];
        return c;
    endfunction
endpackage

// File: rtl/tx_sample_fifo.sv
// Synchronous AM sample FIFO; flush empties it and wins over a same-edge push.
module tx_sample_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  do_push, do_pop;

    assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            // Any pop this edge has already been consumed by the reader via dout
            rd_ptr <= wr_ptr;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/tx_control_interface.sv
// Converts freq/am/ctl stb-ack streams into NCO word, paced AM samples and enables.
// Optional underflow counter built only when TX_UNDERFLOW_COUNT_EN is defined.
module tx_control_interface
    import tx_ctl_pkg::*;
#(
    parameter int SAMPLE_DIVIDER  = 2500,
    parameter int FIFO_DEPTH_LOG2 = 5,
    parameter int AM_WIDTH        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STREAM_WIDTH-1:0]    input_tx_freq,
    input  logic                       input_tx_freq_stb,
    output logic                       input_tx_freq_ack,
    input  logic [STREAM_WIDTH-1:0]    input_tx_am,
    input  logic                       input_tx_am_stb,
    output logic                       input_tx_am_ack,
    input  logic [STREAM_WIDTH-1:0]    input_tx_ctl,
    input  logic                       input_tx_ctl_stb,
    output logic                       input_tx_ctl_ack,
    output logic [STREAM_WIDTH-1:0]    frequency,
    output logic [AM_WIDTH-1:0]        amplitude,
    output logic                       sample_valid,
    output logic                       tx_enable,
    output logic [UNDERFLOW_WIDTH-1:0] underflow_count
);
    localparam int CNT_W = $clog2(SAMPLE_DIVIDER);

    logic             freq_xfer, am_xfer, ctl_xfer;
    ctl_cmd_t         cmd;
    logic             flush, am_enable;
    logic             fifo_full, fifo_empty;
    logic [AM_WIDTH-1:0] fifo_dout;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick, pop;

    assign freq_xfer = input_tx_freq_stb && input_tx_freq_ack;
    assign am_xfer   = input_tx_am_stb && input_tx_am_ack;
    assign ctl_xfer  = input_tx_ctl_stb && input_tx_ctl_ack;
    assign cmd       = decode_ctl(input_tx_ctl[2:0]);
    assign flush     = ctl_xfer && cmd.flush;
    assign tick      = (tick_cnt == CNT_W'(SAMPLE_DIVIDER-1));
    assign pop       = tick && am_enable && !fifo_empty;

    generate
        if (AM_WIDTH < STREAM_WIDTH) begin : g_unused
            logic unused_bits;
            assign unused_bits = ^{input_tx_ctl[STREAM_WIDTH-1:3], input_tx_am[STREAM_WIDTH-1:AM_WIDTH]};
        end else begin : g_unused_ctl
            logic unused_bits;
            assign unused_bits = ^input_tx_ctl[STREAM_WIDTH-1:3];
        end
    endgenerate

    // Each ack is a single-cycle pulse; stb is only looked at while ack is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            input_tx_freq_ack <= 1'b0;
            input_tx_am_ack   <= 1'b0;
            input_tx_ctl_ack  <= 1'b0;
        end else begin
            input_tx_freq_ack <= !input_tx_freq_ack && input_tx_freq_stb;
            input_tx_ctl_ack  <= !input_tx_ctl_ack && input_tx_ctl_stb;
            input_tx_am_ack   <= !input_tx_am_ack && input_tx_am_stb && !fifo_full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frequency <= '0;
            tx_enable <= 1'b0;
            am_enable <= 1'b0;
        end else begin
            if (freq_xfer) frequency <= input_tx_freq;
            if (ctl_xfer) begin
                tx_enable <= cmd.tx_en;
                am_enable <= cmd.am_en;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amplitude    <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= pop;
            if (tick) begin
                if (!am_enable)      amplitude <= '1;
                else if (!fifo_empty) amplitude <= fifo_dout;
            end
        end
    end

`ifdef TX_UNDERFLOW_COUNT_EN
    logic                       starve;
    logic [UNDERFLOW_WIDTH-1:0] underflow_q;

    assign starve = tick && am_enable && fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        underflow_q <= '0;
        else if (starve && !(&underflow_q)) underflow_q <= underflow_q + UNDERFLOW_WIDTH'(1);
    end

    assign underflow_count = underflow_q;
`else
    assign underflow_count = '0;
`endif

    tx_sample_fifo #(
        .WIDTH      (AM_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (am_xfer),
        .pop   (pop),
        .flush (flush),
        .din   (input_tx_am[AM_WIDTH-1:0]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );
endmodule

// File: tb/tb_tx_control_interface.sv
// Self-checking bench for tx_control_interface: vector table, AM scoreboard, corner sequences.
`timescale 1ns/1ps
module tb_tx_control_interface;
    localparam int DIV = 4;
    localparam int AW  = 16;
`ifdef TX_UNDERFLOW_COUNT_EN
    localparam logic [31:0] UF_ONE = 32'd1;
    localparam logic [31:0] UF_SAT = 32'hFFFF;
`else
    localparam logic [31:0] UF_ONE = 32'd0;
    localparam logic [31:0] UF_SAT = 32'd0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    logic [31:0] freq_d = '0, am_d = '0, ctl_d = '0;
    logic freq_stb = 1'b0, am_stb = 1'b0, ctl_stb = 1'b0;
    logic freq_ack, am_ack, ctl_ack;
    logic [31:0] frequency;
    logic [AW-1:0] amplitude;
    logic sample_valid, tx_enable;
    logic [15:0] underflow_count;

    always #5 clk = ~clk;

    tx_control_interface #(.SAMPLE_DIVIDER(DIV), .FIFO_DEPTH_LOG2(5), .AM_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .input_tx_freq(freq_d), .input_tx_freq_stb(freq_stb), .input_tx_freq_ack(freq_ack),
        .input_tx_am(am_d), .input_tx_am_stb(am_stb), .input_tx_am_ack(am_ack),
        .input_tx_ctl(ctl_d), .input_tx_ctl_stb(ctl_stb), .input_tx_ctl_ack(ctl_ack),
        .frequency(frequency), .amplitude(amplitude), .sample_valid(sample_valid),
        .tx_enable(tx_enable), .underflow_count(underflow_count)
    );

    int n_pass = 0, n_total = 0;
    logic [AW-1:0] sb_q[$];
    int cyc = 0, sv_count = 0, last_sv = -1;
    bit pace_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor samples at +1, stimulus side at +2
    always @(posedge clk) begin
        #1;
        if (sample_valid) begin
            sv_count++;
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_sample: got 0x%04h with nothing queued", amplitude);
            end else begin
                logic [AW-1:0] e;
                e = sb_q.pop_front();
                chk("sb_amplitude", 32'(amplitude), 32'(e));
            end
            if (pace_on && last_sv >= 0) chk("pace_gap", 32'(cyc - last_sv), 32'(DIV));
            last_sv = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    function automatic logic ack_of(input int s);
        case (s)
            0:       return freq_ack;
            1:       return am_ack;
            default: return ctl_ack;
        endcase
    endfunction

    task automatic set_stb(input int s, input logic v, input logic [31:0] d);
        case (s)
            0:       begin freq_d = d; freq_stb = v; end
            1:       begin am_d = d;   am_stb = v;   end
            default: begin ctl_d = d;  ctl_stb = v;  end
        endcase
    endtask

    task automatic send(input int s, input logic [31:0] d);
        int n = 0;
        set_stb(s, 1'b1, d);
        while (!ack_of(s) && n < 200) begin step(1); n++; end
        if (!ack_of(s)) begin n_total++; $display("FAIL send_timeout: stream %0d got no ack, required ack", s); end
        step(1);
        if (s == 1) sb_q.push_back(d[AW-1:0]);
        if (s == 2 && d[2]) sb_q.delete();
        set_stb(s, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        set_stb(0, 1'b0, 0); set_stb(1, 1'b0, 0); set_stb(2, 1'b0, 0);
        rst = 1'b1;
        step(2);
        sb_q.delete();
        last_sv = -1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] ctl;
        logic [31:0] freq;
        logic        exp_tx;
        logic [31:0] exp_freq;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int n, base;
        bit saw;
        vecs[0] = '{32'h0000_0001, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0000, 32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[2] = '{32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
        vecs[4] = '{32'h0000_0005, 32'h8000_0000, 1'b1, 32'h8000_0000};

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_frequency", frequency, 32'h0);
        chk("rst_amplitude", 32'(amplitude), 32'h0);
        chk("rst_outputs", {27'h0, sample_valid, tx_enable, freq_ack, am_ack, ctl_ack}, 32'h0);
        chk("rst_underflow", 32'(underflow_count), 32'h0);
        step(2);
        rst = 1'b0;

        // Frequency load and back-to-back spacing
        set_stb(0, 1'b1, 32'h0147_AE14);
        chk("freq_ack_pre", 32'(freq_ack), 32'h0);
        step(1); chk("freq_ack_rise", 32'(freq_ack), 32'h1);
        step(1); chk("freq_ack_drop", 32'(freq_ack), 32'h0);
        chk("freq_load", frequency, 32'h0147_AE14);
        freq_d = 32'h0000_0001;
        step(1); chk("freq_ack2_rise", 32'(freq_ack), 32'h1);
        step(1); chk("freq_load2", frequency, 32'h0000_0001);
        set_stb(0, 1'b0, 0);

        // Control/frequency vector table
        foreach (vecs[i]) begin
            send(2, vecs[i].ctl);
            send(0, vecs[i].freq);
            chk($sformatf("vec%0d_tx_enable", i), 32'(tx_enable), 32'(vecs[i].exp_tx));
            chk($sformatf("vec%0d_frequency", i), frequency, vecs[i].exp_freq);
            chk($sformatf("vec%0d_ctl_ack_low", i), 32'(ctl_ack), 32'h0);
        end

        // AM pacing with underflow on the fourth tick
        do_reset();
        send(1, 32'h1000); send(1, 32'h2000); send(1, 32'h3000);
        pace_on = 1'b1;
        base = sv_count;
        send(2, 32'h3);
        n = 0;
        while (sv_count < base + 3 && n < 60) begin step(1); n++; end
        chk("pace_samples", 32'(sv_count - base), 32'd3);
        pace_on = 1'b0;
        step(DIV - 1);
        chk("pace_underflow_early", 32'(underflow_count), 32'h0);
        step(1);
        chk("pace_underflow", 32'(underflow_count), UF_ONE);
        chk("pace_amp_hold", 32'(amplitude), 32'h3000);

        // Full FIFO: 33rd sample waits for the first pop
        do_reset();
        for (int i = 0; i < 32; i++) send(1, 32'h0100 + 32'(i) * 32'h11);
        set_stb(1, 1'b1, 32'hAAAA);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin step(1); if (am_ack) saw = 1'b1; end
        chk("full_no_ack", 32'(saw), 32'h0);
        base = sv_count;
        send(2, 32'h2);
        n = 0;
        while (!am_ack && n < 40) begin step(1); n++; end
        chk("full_ack_seen", 32'(am_ack), 32'h1);
        chk("full_ack_after_pop", 32'(sv_count > base), 32'h1);
        step(1);
        sb_q.push_back(16'hAAAA);
        set_stb(1, 1'b0, 0);
        n = 0;
        while (sb_q.size() > 0 && n < 400) begin step(1); n++; end
        chk("full_drained", 32'(sb_q.size()), 32'h0);

        // Flush colliding with an AM push
        do_reset();
        send(1, 32'h1111); send(1, 32'h2222);
        step(DIV);
        set_stb(1, 1'b1, 32'hBEEF);
        set_stb(2, 1'b1, 32'h6);
        n = 0;
        while (!(am_ack && ctl_ack) && n < 20) begin step(1); n++; end
        chk("flush_both_ack", {30'h0, am_ack, ctl_ack}, 32'h3);
        step(1);
        sb_q.delete();
        set_stb(1, 1'b0, 0); set_stb(2, 1'b0, 0);
        base = sv_count;
        step(3 * DIV);
        chk("flush_no_samples", 32'(sv_count - base), 32'h0);
        chk("flush_amp", 32'(amplitude), 32'hFFFF);
        send(1, 32'h5555);
        n = 0;
        while (sb_q.size() > 0 && n < 40) begin step(1); n++; end
        chk("flush_next_sample", 32'(sb_q.size()), 32'h0);

        // Reset in the middle of a burst with am ack high
        do_reset();
        send(2, 32'h1); send(0, 32'h55);
        for (int i = 0; i < 5; i++) send(1, 32'h0A00 + 32'(i));
        set_stb(1, 1'b1, 32'h7777);
        n = 0;
        while (!am_ack && n < 20) begin step(1); n++; end
        chk("mid_ack_high", 32'(am_ack), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_frequency", frequency, 32'h0);
        chk("mid_rst_outputs", {27'h0, sample_valid, tx_enable, freq_ack, am_ack, ctl_ack}, 32'h0);
        chk("mid_rst_amp_uf", {amplitude, underflow_count}, 32'h0);
        sb_q.delete();
        step(1);
        rst = 1'b0;
        set_stb(1, 1'b0, 0);
        send(2, 32'h2);
        base = sv_count;
        step(3 * DIV);
        chk("mid_no_samples", 32'(sv_count - base), 32'h0);

        // Disabled AM gives carrier; then underflow saturation
        do_reset();
        send(2, 32'h1);
        step(DIV + 1);
        chk("dis_amp", 32'(amplitude), 32'hFFFF);
        chk("dis_underflow", 32'(underflow_count), 32'h0);
        chk("dis_tx_enable", 32'(tx_enable), 32'h1);
        send(2, 32'h3);
`ifdef TX_UNDERFLOW_COUNT_EN
        force dut.underflow_q = 16'hFFFD;
        step(1);
        release dut.underflow_q;
        step(6 * DIV);
`else
        step(50 * DIV);
`endif
        chk("sat_underflow", 32'(underflow_count), UF_SAT);
        step(2 * DIV);
        chk("sat_hold", 32'(underflow_count), UF_SAT);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tx_control_interface.md
Name: tx_control_interface

Overview:
- Downstream consumer of the processor's three transmitter streams: tx_freq, tx_am and tx_ctl, each 32-bit with stb/ack.
- Turns those streams into stable, clock-synchronous control for the RF transmitter datapath:
  - NCO frequency word
  - paced AM amplitude samples
  - enable flags
- AM samples are buffered in a FIFO and released at a fixed sample rate, so software can burst-write them.

Parameters:
SAMPLE_DIVIDER, 2500, clk cycles per AM sample tick (100 MHz / 40 kHz); legal range 2..65535
FIFO_DEPTH_LOG2, 5, AM FIFO depth = 2**FIFO_DEPTH_LOG2 entries (32)
AM_WIDTH, 16, amplitude width taken from input_tx_am[AM_WIDTH-1:0], unsigned

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
input_tx_freq  in  32  frequency word stream data
input_tx_freq_stb  in  1  data valid
input_tx_freq_ack  out  1  accept
input_tx_am  in  32  AM sample stream data
input_tx_am_stb  in  1  data valid
input_tx_am_ack  out  1  accept
input_tx_ctl  in  32  control word stream data
input_tx_ctl_stb  in  1  data valid
input_tx_ctl_ack  out  1  accept
frequency  out  32  NCO phase increment
amplitude  out  AM_WIDTH  current AM amplitude
sample_valid  out  1  one-cycle pulse when amplitude is updated from the FIFO
tx_enable  out  1  transmitter enable
underflow_count  out  16  saturating count of sample ticks that found the FIFO empty

Behaviour:
- Reset: asynchronous, active-high, clock clk. Asserting rst forces, immediately:
  - frequency=0, amplitude=0, sample_valid=0, tx_enable=0, underflow_count=0
  - all ack outputs=0
  - FIFO empty, internal am_enable=0, tick counter=0
- Handshake, all three streams:
  - A transfer occurs on a rising edge where stb && ack.
  - ack is registered. It rises the cycle after stb is seen high with no transfer pending, stays high for exactly one cycle, then drops.
  - stb is sampled only while ack is low. Producer holds data and stb until ack.
  - Back-to-back transfers are therefore at most one per 2 cycles per stream.
- freq stream: always accepted. frequency loads input_tx_freq on the transfer edge, i.e. visible 1 cycle after ack.
- ctl stream: always accepted. On transfer:
  - bit0 -> tx_enable (registered).
  - bit1 -> am_enable (registered).
  - bit2 = flush pulse, not stored. Empties the FIFO that cycle. An AM push on the same edge is discarded (ack still given). A pop on the same edge still completes.
  - bits 31:3 ignored.
- am stream: ack may rise only if the FIFO is not full at the sampling edge. On transfer, input_tx_am[AM_WIDTH-1:0] is pushed.
- Tick counter: counts 0..SAMPLE_DIVIDER-1 and wraps. tick = (count == SAMPLE_DIVIDER-1). The counter runs regardless of enables.
- On a tick:
  - am_enable=1, FIFO non-empty: pop; amplitude <= head; sample_valid=1 for one cycle.
  - am_enable=1, FIFO empty: amplitude holds; underflow_count += 1, saturating at 0xFFFF.
  - am_enable=0: amplitude <= all ones (unmodulated carrier), FIFO not popped, no underflow counted.
- Simultaneous push and pop, including when full: both occur and the level is unchanged.
  - ack eligibility uses the level before the edge, so a full FIFO never acks even if a pop happens that cycle.
- Status outputs: tx_enable gates nothing internally; the transmitter uses it.

Optional Feature:
- Macro: TX_UNDERFLOW_COUNT_EN.
- Defined: underflow_count behaves as specified above.
- Undefined: counter logic is omitted and underflow_count is tied to 0. All other behaviour is unchanged.

Decomposition:
- Package tx_ctl_pkg:
  - CTL_TX_EN_BIT=0, CTL_AM_EN_BIT=1, CTL_FLUSH_BIT=2
  - STREAM_WIDTH=32, UNDERFLOW_WIDTH=16
- Sub-module tx_sample_fifo:
  - synchronous FIFO, parameterised width/depth
  - ports: push, pop, flush, full, empty, dout
  - flush has priority over push

Test Plan:
- Reset mid-burst:
  - Stimulus: assert rst while the FIFO holds 5 samples and am ack is high.
  - Response: all outputs 0 immediately; after release, FIFO empty and the first tick gives no sample_valid.
- Frequency load:
  - Stimulus: freq stream sends 0x0147AE14.
  - Response: ack pulses 1 cycle after stb; frequency=0x0147AE14 one cycle after ack; the second word 0x00000001 is accepted ≥2 cycles later.
- AM pacing:
  - Stimulus: SAMPLE_DIVIDER=4; ctl=0x3; push 0x1000, 0x2000, 0x3000.
  - Response: amplitude steps 0x1000→0x2000→0x3000 on consecutive ticks, 4 cycles apart, each with a one-cycle sample_valid; the 4th tick gives underflow_count=1.
- Full FIFO:
  - Stimulus: am_enable=0, push 33 samples with depth 32.
  - Response: 32 acks; the 33rd stb is held unacked until ctl=0x2 enables popping, then it is acked after the first pop.
- Flush collision:
  - Stimulus: ctl=0x6 transfer on the same edge as an AM push of 0xBEEF.
  - Response: FIFO empty afterwards; 0xBEEF is never output; am ack was still given.
- Disabled AM and saturation:
  - Stimulus: ctl=0x1.
  - Response: amplitude=0xFFFF on the next tick, no underflow.
  - Stimulus: force 65540 empty ticks with am_enable=1.
  - Response: underflow_count=0xFFFF (0 with TX_UNDERFLOW_COUNT_EN undefined).
